// File: rtl/qsys_nios2cpu_oci_dct_sequencer.sv
// rtl/qsys_nios2cpu_oci_dct_sequencer.sv - OCI DCT trace atom sequencer and frame packer
//
// Packs trace atoms into a shift buffer (dct_buffer/dct_count). Full frames,
// and the partial frame left at stop, move into a holding register that is
// offered downstream over frm_valid/frm_ready. test_ending and test_has_ended
// tell the OCI test bench how far the end-of-trace sequence has progressed.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   arm, stop                 capture control pulses
//   atom_valid, atom_data     incoming trace atoms (no backpressure)
//   frm_valid/ready/data/count  frame output to the trace store
//   dct_buffer, dct_count     live packing buffer and its atom count
//   test_ending               high while flushing
//   test_has_ended            high once capture has fully finished
//   ovf, ovf_count            dropped-atom flag and saturating count
module qsys_nios2cpu_oci_dct_sequencer #(
  parameter int ATOM_W    = 2,
  parameter int DCT_ATOMS = 15,
  parameter int CNT_W     = 4,
  parameter int OVF_W     = 8,
  parameter int BUF_W     = ATOM_W * DCT_ATOMS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              stop,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic [BUF_W-1:0]  frm_data,
  output logic [CNT_W-1:0]  frm_count,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_ending,
  output logic              test_has_ended,
  output logic              ovf,
  output logic [OVF_W-1:0]  ovf_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DCT_ATOMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DCT_ATOMS - 1);

  logic [1:0]       state, next_state;
  logic             cap, flush, hold_free, full, accept, drop, arm_ok;
  logic             load_new, load_buf, load_swap;
  logic [BUF_W-1:0] shifted;

  always_comb begin
    cap       = (state == S_CAPTURE);
    flush     = (state == S_FLUSH);
    hold_free = !frm_valid || frm_ready;
    full      = (dct_count == FULL);
    accept    = atom_valid && cap && (!full || hold_free);
    drop      = atom_valid && cap && !accept;
    arm_ok    = arm && (state == S_IDLE || state == S_DONE);
    shifted   = {dct_buffer[BUF_W-ATOM_W-1:0], atom_data};
    // Full buffer already waiting while a new atom arrives: ship the old
    // frame and start the next one with this atom.
    load_swap = accept && full;
    // The arriving atom completes the frame: ship buffer plus atom.
    load_new  = accept && hold_free && (dct_count == LAST);
    // No atom consumed: ship a waiting full frame, or the partial frame in FLUSH.
    load_buf  = hold_free && !accept && (dct_count != '0) && (full || flush);

    next_state = state;
    case (state)
      S_IDLE:    if (arm) next_state = S_CAPTURE;
      S_CAPTURE: if (stop) next_state = S_FLUSH;
      S_FLUSH:   if (dct_count == '0 && !frm_valid) next_state = S_DONE;
      default:   if (arm) next_state = S_CAPTURE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      frm_valid      <= 1'b0;
      frm_data       <= '0;
      frm_count      <= '0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
      ovf            <= 1'b0;
      ovf_count      <= '0;
    end else begin
      state          <= next_state;
      // Decoded from next_state so the flags line up with the state itself.
      test_ending    <= (next_state == S_FLUSH);
      test_has_ended <= (next_state == S_DONE);

      if (load_swap) begin
        frm_data   <= dct_buffer;
        frm_count  <= FULL;
        dct_buffer <= BUF_W'(atom_data);
        dct_count  <= CNT_W'(1);
      end else if (load_new) begin
        frm_data   <= shifted;
        frm_count  <= FULL;
        dct_buffer <= '0;
        dct_count  <= '0;
      end else if (load_buf) begin
        frm_data   <= dct_buffer;
        frm_count  <= dct_count;
        dct_buffer <= '0;
        dct_count  <= '0;
      end else if (accept) begin
        dct_buffer <= shifted;
        dct_count  <= dct_count + CNT_W'(1);
      end else if (arm_ok) begin
        dct_buffer <= '0;
        dct_count  <= '0;
      end

      // A reload on the handshake edge keeps frm_valid high: no bubble.
      if (load_swap || load_new || load_buf) frm_valid <= 1'b1;
      else if (frm_ready)                    frm_valid <= 1'b0;

      if (arm_ok) begin
        ovf       <= 1'b0;
        ovf_count <= '0;
      end else if (drop) begin
        ovf <= 1'b1;
        if (ovf_count != '1) ovf_count <= ovf_count + OVF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_qsys_nios2cpu_oci_dct_sequencer.sv
// tb/tb_qsys_nios2cpu_oci_dct_sequencer.sv - directed self-checking bench for the DCT sequencer
module tb_qsys_nios2cpu_oci_dct_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm = 1'b0;
  logic        stop = 1'b0;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_data = 2'b00;
  logic        frm_valid;
  logic        frm_ready = 1'b0;
  logic [29:0] frm_data;
  logic [3:0]  frm_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic        ovf;
  logic [7:0]  ovf_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qsys_nios2cpu_oci_dct_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .arm            (arm),
    .stop           (stop),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .frm_valid      (frm_valid),
    .frm_ready      (frm_ready),
    .frm_data       (frm_data),
    .frm_count      (frm_count),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .ovf            (ovf),
    .ovf_count      (ovf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    arm = 1'b0; stop = 1'b0; atom_valid = 1'b0; atom_data = 2'b00; frm_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_frm_valid", 32'(frm_valid), 32'd0);
    chk("rst_frm_data", 32'(frm_data), 32'd0);
    chk("rst_dct_count", 32'(dct_count), 32'd0);
    chk("rst_ending", 32'(test_ending), 32'd0);
    chk("rst_ended", 32'(test_has_ended), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // 1: full frame with ready high
    do_arm();
    frm_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      atom_valid = 1'b1;
      atom_data  = 2'(i % 4);
      tick();
      if (i == 13) begin
        chk("t1_cnt14", 32'(dct_count), 32'd14);
        chk("t1_nofrm14", 32'(frm_valid), 32'd0);
      end
    end
    atom_valid = 1'b0;
    chk("t1_frm_valid", 32'(frm_valid), 32'd1);
    chk("t1_frm_count", 32'(frm_count), 32'd15);
    chk("t1_frm_data", 32'(frm_data), 32'h06C6C6C6);
    chk("t1_dct_count", 32'(dct_count), 32'd0);
    tick();
    chk("t1_drained", 32'(frm_valid), 32'd0);

    // 2: partial frame flushed by stop
    for (int i = 0; i < 5; i++) begin
      atom_valid = 1'b1;
      atom_data  = 2'b11;
      tick();
    end
    atom_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_ending", 32'(test_ending), 32'd1);
    tick();
    chk("t2_frm_valid", 32'(frm_valid), 32'd1);
    chk("t2_frm_count", 32'(frm_count), 32'd5);
    chk("t2_frm_data", 32'(frm_data), 32'h3FF);
    tick();
    chk("t2_drained", 32'(frm_valid), 32'd0);
    chk("t2_not_ended_yet", 32'(test_has_ended), 32'd0);
    tick();
    chk("t2_ended", 32'(test_has_ended), 32'd1);
    chk("t2_ending_off", 32'(test_ending), 32'd0);

    // 3: backpressure, overflow, back-to-back frames
    frm_ready = 1'b0;
    do_arm();
    chk("t3_ended_off", 32'(test_has_ended), 32'd0);
    for (int i = 0; i < 32; i++) begin
      atom_valid = 1'b1;
      atom_data  = 2'(i % 4);
      tick();
    end
    atom_valid = 1'b0;
    chk("t3_frm_valid", 32'(frm_valid), 32'd1);
    chk("t3_frm_data1", 32'(frm_data), 32'h06C6C6C6);
    chk("t3_dct_count", 32'(dct_count), 32'd15);
    chk("t3_dct_buffer", 32'(dct_buffer), 32'h31B1B1B1);
    chk("t3_ovf", 32'(ovf), 32'd1);
    chk("t3_ovf_count", 32'(ovf_count), 32'd2);
    frm_ready = 1'b1;
    tick();
    chk("t3_no_bubble", 32'(frm_valid), 32'd1);
    chk("t3_frm_data2", 32'(frm_data), 32'h31B1B1B1);
    chk("t3_frm_count2", 32'(frm_count), 32'd15);
    chk("t3_dct_count0", 32'(dct_count), 32'd0);
    tick();
    chk("t3_drained", 32'(frm_valid), 32'd0);

    // 5: stop with empty buffer, then re-arm clears overflow
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5_ending", 32'(test_ending), 32'd1);
    tick();
    chk("t5_ended", 32'(test_has_ended), 32'd1);
    chk("t5_ending_off", 32'(test_ending), 32'd0);
    chk("t5_no_frame", 32'(frm_valid), 32'd0);
    chk("t5_ovf_kept", 32'(ovf_count), 32'd2);
    do_arm();
    chk("t5_capture", 32'(test_has_ended), 32'd0);
    chk("t5_ovf_clr", 32'(ovf), 32'd0);
    chk("t5_ovf_cnt_clr", 32'(ovf_count), 32'd0);

    // 4: full buffer waiting, ready and atom arrive together
    do_reset();
    do_arm();
    for (int i = 0; i < 30; i++) begin
      atom_valid = 1'b1;
      atom_data  = 2'b01;
      tick();
    end
    chk("t4_full", 32'(dct_count), 32'd15);
    chk("t4_held", 32'(frm_valid), 32'd1);
    frm_ready  = 1'b1;
    atom_data  = 2'b10;
    tick();
    atom_valid = 1'b0;
    chk("t4_frm_valid", 32'(frm_valid), 32'd1);
    chk("t4_frm_data", 32'(frm_data), 32'h15555555);
    chk("t4_dct_count", 32'(dct_count), 32'd1);
    chk("t4_dct_buffer", 32'(dct_buffer), 32'd2);
    chk("t4_no_drop", 32'(ovf_count), 32'd0);
    tick();
    chk("t4_drained", 32'(frm_valid), 32'd0);

    // 6: asynchronous reset mid-frame
    do_reset();
    do_arm();
    for (int i = 0; i < 22; i++) begin
      atom_valid = 1'b1;
      atom_data  = 2'b10;
      tick();
    end
    atom_valid = 1'b0;
    chk("t6_cnt7", 32'(dct_count), 32'd7);
    chk("t6_held", 32'(frm_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_frm_valid", 32'(frm_valid), 32'd0);
    chk("t6_frm_data", 32'(frm_data), 32'd0);
    chk("t6_dct_count", 32'(dct_count), 32'd0);
    chk("t6_dct_buffer", 32'(dct_buffer), 32'd0);
    chk("t6_frm_count", 32'(frm_count), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    stop = 1'b1;
    atom_valid = 1'b1;
    tick();
    stop = 1'b0;
    atom_valid = 1'b0;
    chk("t6_idle_stop", 32'(test_ending), 32'd0);
    chk("t6_idle_atom", 32'(dct_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
